// File: rtl/hub75_scan_ctrl_if.sv
// Signal bundle between hub75_scan_ctrl, its pixel_generator and the HUB75 panel.
// SCAN_DIMMING_EN adds the brightness input.
interface hub75_scan_ctrl_if #(
  parameter int COLS = 32,
  parameter int ROWS = 8
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          enable;
  logic [CW-1:0] col_count;
  logic [RW-1:0] row_count;
  logic [2:0]    LED_Top;
  logic [2:0]    LED_Bottom;
  logic [2:0]    rgb_top;
  logic [2:0]    rgb_bot;
  logic          panel_clk;
  logic          panel_lat;
  logic          panel_oe_n;
  logic [RW-1:0] panel_addr;
  logic          frame_start;
`ifdef SCAN_DIMMING_EN
  logic [3:0]    brightness;
`endif

  modport master (
    input  enable, LED_Top, LED_Bottom,
`ifdef SCAN_DIMMING_EN
    input  brightness,
`endif
    output col_count, row_count, rgb_top, rgb_bot, panel_clk, panel_lat,
           panel_oe_n, panel_addr, frame_start
  );

  modport slave (
    output enable, LED_Top, LED_Bottom,
`ifdef SCAN_DIMMING_EN
    output brightness,
`endif
    input  col_count, row_count, rgb_top, rgb_bot, panel_clk, panel_lat,
           panel_oe_n, panel_addr, frame_start
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// Row-pair scan controller for a 32x16 HUB75 panel: shift, blank, latch, light.
// Optional SCAN_DIMMING_EN limits the lit columns per row via bus.brightness.
//
// state | meaning
// IDLE  | not scanning, panel dark, waits for enable
// SHIFT | clocking one row pair out, previous latched row lit
// BLANK | panel dark before the latch
// LATCH | one-cycle latch strobe, address update
module hub75_scan_ctrl #(
  parameter int COLS         = 32,
  parameter int ROWS         = 8,
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  hub75_scan_ctrl_if.master  bus
);
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int TMAX = (2*CLK_DIV > BLANK_CYCLES) ? 2*CLK_DIV : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX);

  // Tick is a down-counter: tick = 2*CLK_DIV-1-t within a column.
  localparam logic [TW-1:0] TICK_TOP  = TW'(2*CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_RGB  = TW'(2*CLK_DIV - 2);
  localparam logic [TW-1:0] HALF      = TW'(CLK_DIV);
  localparam logic [TW-1:0] BLANK_TOP = TW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, BLANK, LATCH} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          lit_q, lit_d;
  logic [2:0]    rgb_top_q, rgb_top_d;
  logic [2:0]    rgb_bot_q, rgb_bot_d;
  logic          pclk_q, pclk_d;
  logic          lat_q, lat_d;
  logic          oe_n_q, oe_n_d;
  logic [RW-1:0] addr_q, addr_d;
  logic          fs_q, fs_d;
  logic          on_col;
`ifdef SCAN_DIMMING_EN
  logic [3:0]    bright_q, bright_d;
  logic [31:0]   on_cols;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    col_d     = col_q;
    row_d     = row_q;
    lit_d     = lit_q;
    rgb_top_d = rgb_top_q;
    rgb_bot_d = rgb_bot_q;
    addr_d    = addr_q;
`ifdef SCAN_DIMMING_EN
    bright_d  = bright_q;
    on_cols   = 32'd0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = SHIFT;
          tick_d  = TICK_TOP;
          col_d   = '0;
        end
      end
      SHIFT: begin
        if (tick_q == TICK_RGB) begin
          rgb_top_d = bus.LED_Top;
          rgb_bot_d = bus.LED_Bottom;
        end
        if (tick_q == '0) begin
          if (col_q == LAST_COL) begin
            state_d = BLANK;
            tick_d  = BLANK_TOP;
          end else begin
            col_d  = col_q + CW'(1);
            tick_d = TICK_TOP;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      BLANK: begin
        if (tick_q == '0) state_d = LATCH;
        else              tick_d  = tick_q - TW'(1);
      end
      LATCH: begin
        row_d   = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        col_d   = '0;
        tick_d  = TICK_TOP;
        lit_d   = 1'b1;
`ifdef SCAN_DIMMING_EN
        bright_d = bus.brightness;
`endif
        state_d = bus.enable ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SCAN_DIMMING_EN
    on_cols = ((32'(bright_d) + 32'd1) * 32'(COLS)) >> 4;
    on_col  = (32'(col_d) < on_cols);
`else
    on_col  = 1'b1;
`endif

    // Outputs are derived from next state so they line up with the state register.
    pclk_d = (state_d == SHIFT) && (tick_d < HALF);
    lat_d  = (state_d == LATCH);
    oe_n_d = !((state_d == SHIFT) && lit_d && on_col);
    fs_d   = (state_d == SHIFT) && (state_q != SHIFT) && (row_d == '0);
    if (state_d == LATCH) addr_d = row_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      lit_q     <= 1'b0;
      rgb_top_q <= '0;
      rgb_bot_q <= '0;
      pclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      oe_n_q    <= 1'b1;
      addr_q    <= '0;
      fs_q      <= 1'b0;
`ifdef SCAN_DIMMING_EN
      bright_q  <= 4'hF;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lit_q     <= lit_d;
      rgb_top_q <= rgb_top_d;
      rgb_bot_q <= rgb_bot_d;
      pclk_q    <= pclk_d;
      lat_q     <= lat_d;
      oe_n_q    <= oe_n_d;
      addr_q    <= addr_d;
      fs_q      <= fs_d;
`ifdef SCAN_DIMMING_EN
      bright_q  <= bright_d;
`endif
    end
  end

  assign bus.col_count   = col_q;
  assign bus.row_count   = row_q;
  assign bus.rgb_top     = rgb_top_q;
  assign bus.rgb_bot     = rgb_bot_q;
  assign bus.panel_clk   = pclk_q;
  assign bus.panel_lat   = lat_q;
  assign bus.panel_oe_n  = oe_n_q;
  assign bus.panel_addr  = addr_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: random images, queued per-column and per-latch expectations.
module tb_hub75_scan_ctrl;
  localparam int COLS = 32;
  localparam int ROWS = 8;
  localparam int CLK_DIV = 4;
  localparam int BLANK = 2;
  localparam int ROW_P = COLS*2*CLK_DIV + BLANK + 1;
  localparam int FRAME_P = ROW_P*ROWS;

  typedef struct { int row; int col; int top; int bot; } sh_t;
  typedef struct { int addr; int ival; int oe_exp; } lt_t;

  logic clk = 1'b0;
  logic reset_n;
  hub75_scan_ctrl_if bus ();

  hub75_scan_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  logic [2:0] img_top [0:ROWS-1][0:COLS-1];
  logic [2:0] img_bot [0:ROWS-1][0:COLS-1];

  sh_t sq[$];
  lt_t lq[$];
  int  fs_q[$];
  int  n_cmp = 0, n_err = 0;
  int  cyc = 0, lat_cnt = 0, fs_cnt = 0, edge_cnt = 0;
  int  model_row = 0;
  bit  lit_m = 0;
  int  bright = 15;

  // Pixel generator stand-in: registered lookup, one clk behind col/row.
  always @(posedge clk) begin
    bus.LED_Top    <= img_top[bus.row_count][bus.col_count];
    bus.LED_Bottom <= img_bot[bus.row_count][bus.col_count];
  end

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int outs();
    return int'({bus.col_count, bus.row_count, bus.rgb_top, bus.rgb_bot, bus.panel_clk,
                 bus.panel_lat, bus.panel_oe_n, bus.panel_addr, bus.frame_start});
  endfunction

  function automatic int on_exp();
    return ((bright + 1) * COLS / 16) * 2 * CLK_DIV;
  endfunction

  // Monitor
  bit prev_pclk = 0, prev_lat = 0;
  int oe_low = 0, hi_run = 0, lat_w = 0, last_lat = 0;
  always @(negedge clk) begin
    sh_t s;
    lt_t l;
    cyc++;
    if (!reset_n) begin
      prev_pclk = 0; prev_lat = 0; oe_low = 0; hi_run = 0; lat_w = 0; last_lat = 0;
    end else begin
      if (bus.panel_clk && !prev_pclk) begin
        edge_cnt++;
        chk("shift_expected", int'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          s = sq.pop_front();
          chk("shift_row", int'(bus.row_count), s.row);
          chk("shift_col", int'(bus.col_count), s.col);
          chk("rgb_top", int'(bus.rgb_top), s.top);
          chk("rgb_bot", int'(bus.rgb_bot), s.bot);
        end
      end
      if (bus.frame_start) begin
        fs_cnt++;
        fs_q.push_back(cyc);
        chk("frame_expected", int'(sq.size() > 0), 1);
        if (sq.size() > 0) chk("frame_pos", sq[0].row * 100 + sq[0].col, 0);
      end
      if (bus.panel_lat && !prev_lat) begin
        chk("latch_expected", int'(lq.size() > 0), 1);
        if (lq.size() > 0) begin
          l = lq.pop_front();
          chk("latch_addr", int'(bus.panel_addr), l.addr);
          if (l.ival > 0) chk("latch_interval", cyc - last_lat, l.ival);
          chk("oe_low_cycles", oe_low, l.oe_exp);
          if (l.oe_exp > 0 && bright == 15) chk("blank_cycles", hi_run, BLANK);
        end
        last_lat = cyc;
        oe_low = 0;
        lat_cnt++;
      end
      if (bus.panel_lat) lat_w++;
      else if (prev_lat) begin
        chk("latch_width", lat_w, 1);
        lat_w = 0;
      end
      if (!bus.panel_oe_n) begin oe_low++; hi_run = 0; end
      else hi_run++;
      prev_pclk = bus.panel_clk;
      prev_lat  = bus.panel_lat;
    end
  end

  task automatic randomize_image();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        img_top[r][c] = 3'($urandom_range(0, 7));
        img_bot[r][c] = 3'($urandom_range(0, 7));
        if (r == 0) begin img_top[r][c] = 3'b111; img_bot[r][c] = 3'b111; end
        if (r == 2) begin img_top[r][c] = 3'b100; img_bot[r][c] = 3'b100; end
        if (r == 7) begin img_top[r][c] = 3'b101; img_bot[r][c] = 3'b101; end
      end
  endtask

  task automatic push_rows(input int n, output int fs_exp);
    int  r;
    sh_t s;
    lt_t l;
    fs_exp = 0;
    for (int i = 0; i < n; i++) begin
      r = model_row;
      if (r == 0) fs_exp++;
      for (int c = 0; c < COLS; c++) begin
        s.row = r; s.col = c; s.top = int'(img_top[r][c]); s.bot = int'(img_bot[r][c]);
        sq.push_back(s);
      end
      l.addr = r;
      l.ival = (i > 0) ? ROW_P : 0;
      l.oe_exp = lit_m ? on_exp() : 0;
      lq.push_back(l);
      lit_m = 1;
      model_row = (r + 1) % ROWS;
    end
  endtask

  task automatic wait_lat(input int target, input int budget);
    int k = 0;
    while (lat_cnt < target && k < budget) begin @(negedge clk); k++; end
    chk("latch_reached", int'(lat_cnt >= target), 1);
  endtask

  task automatic wait_col(input int col);
    int k = 0;
    while (int'(bus.col_count) != col && k < ROW_P + 50) begin @(negedge clk); k++; end
    chk("col_reached", int'(bus.col_count), col);
  endtask

  task automatic run_rows(input int n, input int stop_col, input bit do_rst);
    int base, fbase, fexp, e0;
    base = lat_cnt; fbase = fs_cnt; fs_q.delete();
    push_rows(n, fexp);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    if (do_rst) begin
      wait_col(17);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("reset_vals_mid", outs(),
            int'({5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}));
      end
      sq.delete(); lq.delete(); fs_q.delete();
      model_row = 0; lit_m = 0;
      base = lat_cnt; fbase = fs_cnt;
      push_rows(n, fexp);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    wait_lat(base + n - 1, n * ROW_P + 50);
    wait_col(stop_col);
    bus.enable = 1'b0;
    wait_lat(base + n, ROW_P + 50);
    e0 = edge_cnt;
    repeat (40) @(negedge clk);
    chk("idle_no_edges", edge_cnt - e0, 0);
    chk("idle_oe_n", int'(bus.panel_oe_n), 1);
    chk("idle_panel_clk", int'(bus.panel_clk), 0);
    chk("shift_queue_drained", sq.size(), 0);
    chk("latch_queue_drained", lq.size(), 0);
    chk("frame_count", fs_cnt - fbase, fexp);
    for (int i = 1; i < fs_q.size(); i++) chk("frame_period", fs_q[i] - fs_q[i-1], FRAME_P);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0;
`ifdef SCAN_DIMMING_EN
    bus.brightness = 4'($urandom_range(0, 15));
    bright = int'(bus.brightness);
`endif
    randomize_image();
    repeat (3) begin
      @(negedge clk);
      chk("reset_vals", outs(), int'({5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}));
    end
    reset_n = 1'b1;
    @(negedge clk);

    run_rows(18, $urandom_range(1, 30), 1'b0);
    run_rows(2, 10, 1'b0);
    randomize_image();
    run_rows($urandom_range(1, 4), $urandom_range(1, 30), 1'b0);
    run_rows(3, $urandom_range(1, 30), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
